// File: rtl/rv32i_types.sv
// Shared types and default tuning constants for the pipelined/OoO core scheduler.
package rv32i_types;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PC_W  = 32;

    localparam int unsigned DEF_WINDOW        = 256;
    localparam int unsigned DEF_TO_OOO_THRESH = 64;
    localparam int unsigned DEF_TO_PPL_THRESH = 16;
    localparam int unsigned DEF_ROB_LOW       = 8;
    localparam int unsigned DEF_COOLDOWN      = 2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_HANDOFF  = 2'd2,
        ST_COOLDOWN = 2'd3
    } sched_state_t;

    typedef enum logic {
        CORE_PPL = 1'b0,
        CORE_OOO = 1'b1
    } core_sel_t;

    // One core's per-cycle event strobes.
    typedef struct packed {
        logic mult;
        logic mem_op;
        logic flush;
        logic alu_op;
        logic rob_full;
    } core_events_t;

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_event_counter
    import rv32i_types::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hw_scheduler.sv
// Window-based scheduler that migrates execution between the pipelined and OoO cores
// by draining the active core and handing its resume PC to the other one.
module hw_scheduler
    import rv32i_types::*;
#(
    parameter int unsigned WINDOW        = DEF_WINDOW,
    parameter int unsigned TO_OOO_THRESH = DEF_TO_OOO_THRESH,
    parameter int unsigned TO_PPL_THRESH = DEF_TO_PPL_THRESH,
    parameter int unsigned ROB_LOW       = DEF_ROB_LOW,
    parameter int unsigned COOLDOWN      = DEF_COOLDOWN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sched_enable,
    input  logic            ppl_mult_counter_en,
    input  logic            ppl_mem_op_counter_en,
    input  logic            ppl_flush_counter_en,
    input  logic            ppl_alu_op_counter_en,
    input  logic            ppl_rob_full_threshold,
    input  logic            ooo_mult_counter_en,
    input  logic            ooo_mem_op_counter_en,
    input  logic            ooo_flush_counter_en,
    input  logic            ooo_alu_op_counter_en,
    input  logic            ooo_rob_full_threshold,
    input  logic            ppl_drain_ack,
    input  logic            ooo_drain_ack,
    input  logic [PC_W-1:0] ppl_resume_pc,
    input  logic [PC_W-1:0] ooo_resume_pc,
    output logic            ppl_drain_req,
    output logic            ooo_drain_req,
    output logic            ppl_en,
    output logic            ooo_en,
    output logic            hardware_scheduler_swap_pc,
    output logic [PC_W-1:0] hardware_scheduler_pc,
    output logic            active_core
);

    localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned CD_W  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    sched_state_t     state, state_nxt;
    core_sel_t        core_q, core_nxt;
    logic [WIN_W-1:0] win_cnt;
    logic [CD_W-1:0]  cd_cnt, cd_nxt;
    core_events_t     ppl_ev, ooo_ev, act_ev;
    logic             counting, window_end, cnt_clr, cnt_en;
    logic [CNT_W-1:0] mult_cnt, mem_cnt, flush_cnt, alu_cnt, rob_cnt;
    logic [SUM_W-1:0] mult_mem_sum;
    logic             want_swap, drain_ack;
    logic [PC_W-1:0]  resume_pc, pc_nxt;
    logic             ppl_en_nxt, ooo_en_nxt, ppl_drain_nxt, ooo_drain_nxt, swap_nxt;
    logic             unused_alu;

    assign ppl_ev = '{mult: ppl_mult_counter_en, mem_op: ppl_mem_op_counter_en,
                      flush: ppl_flush_counter_en, alu_op: ppl_alu_op_counter_en,
                      rob_full: ppl_rob_full_threshold};
    assign ooo_ev = '{mult: ooo_mult_counter_en, mem_op: ooo_mem_op_counter_en,
                      flush: ooo_flush_counter_en, alu_op: ooo_alu_op_counter_en,
                      rob_full: ooo_rob_full_threshold};
    assign act_ev    = (core_q == CORE_OOO) ? ooo_ev : ppl_ev;
    assign drain_ack = (core_q == CORE_OOO) ? ooo_drain_ack : ppl_drain_ack;
    assign resume_pc = (core_q == CORE_OOO) ? ooo_resume_pc : ppl_resume_pc;

    assign counting   = (state == ST_RUN) || (state == ST_COOLDOWN);
    assign window_end = counting && (win_cnt == WIN_W'(WINDOW - 1));
    // HANDOFF also clears so the new core starts on a fresh, aligned window.
    assign cnt_clr    = window_end || (state == ST_HANDOFF);
    assign cnt_en     = counting && !window_end;

    sat_event_counter u_mult  (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_en && act_ev.mult),     .count(mult_cnt));
    sat_event_counter u_mem   (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_en && act_ev.mem_op),   .count(mem_cnt));
    sat_event_counter u_flush (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_en && act_ev.flush),    .count(flush_cnt));
    sat_event_counter u_alu   (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_en && act_ev.alu_op),   .count(alu_cnt));
    sat_event_counter u_rob   (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(cnt_en && act_ev.rob_full), .count(rob_cnt));

    assign unused_alu   = ^alu_cnt;
    assign mult_mem_sum = {1'b0, mult_cnt} + {1'b0, mem_cnt};
    assign want_swap    = (core_q == CORE_PPL)
                        ? (mult_mem_sum >= SUM_W'(TO_OOO_THRESH))
                        : ((flush_cnt >= CNT_W'(TO_PPL_THRESH)) && (rob_cnt < CNT_W'(ROB_LOW)));

    // Window position; frozen while draining.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_HANDOFF) || window_end) begin
            win_cnt <= '0;
        end else if (counting) begin
            win_cnt <= win_cnt + WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                      <= ST_RUN;
            core_q                     <= CORE_PPL;
            cd_cnt                     <= '0;
            ppl_en                     <= 1'b1;
            ooo_en                     <= 1'b0;
            ppl_drain_req              <= 1'b0;
            ooo_drain_req              <= 1'b0;
            hardware_scheduler_swap_pc <= 1'b0;
            hardware_scheduler_pc      <= '0;
        end else begin
            state                      <= state_nxt;
            core_q                     <= core_nxt;
            cd_cnt                     <= cd_nxt;
            ppl_en                     <= ppl_en_nxt;
            ooo_en                     <= ooo_en_nxt;
            ppl_drain_req              <= ppl_drain_nxt;
            ooo_drain_req              <= ooo_drain_nxt;
            hardware_scheduler_swap_pc <= swap_nxt;
            hardware_scheduler_pc      <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        core_nxt      = core_q;
        cd_nxt        = cd_cnt;
        pc_nxt        = hardware_scheduler_pc;
        swap_nxt      = 1'b0;
        ppl_drain_nxt = 1'b0;
        ooo_drain_nxt = 1'b0;
        ppl_en_nxt    = (core_q == CORE_PPL);
        ooo_en_nxt    = (core_q == CORE_OOO);
        case (state)
            ST_RUN: begin
                if (window_end && sched_enable && want_swap) begin
                    state_nxt     = ST_DRAIN;
                    ppl_drain_nxt = (core_q == CORE_PPL);
                    ooo_drain_nxt = (core_q == CORE_OOO);
                    ppl_en_nxt    = 1'b0;
                    ooo_en_nxt    = 1'b0;
                end
            end
            ST_DRAIN: begin
                ppl_en_nxt = 1'b0;
                ooo_en_nxt = 1'b0;
                if (drain_ack) begin
                    state_nxt = ST_HANDOFF;
                    swap_nxt  = 1'b1;
                    pc_nxt    = resume_pc;
                    core_nxt  = (core_q == CORE_PPL) ? CORE_OOO : CORE_PPL;
                end else begin
                    ppl_drain_nxt = ppl_drain_req;
                    ooo_drain_nxt = ooo_drain_req;
                end
            end
            ST_HANDOFF: begin
                cd_nxt    = '0;
                state_nxt = (COOLDOWN == 0) ? ST_RUN : ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (window_end) begin
                    if (cd_cnt == CD_W'(COOLDOWN - 1)) begin
                        state_nxt = ST_RUN;
                        cd_nxt    = '0;
                    end else begin
                        cd_nxt = cd_cnt + CD_W'(1);
                    end
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign active_core = core_q;

endmodule

// File: tb/tb_hw_scheduler.sv
// Randomized scoreboard bench for hw_scheduler: window-level reference model plus
// a second instance with a very long window for counter saturation.
module tb_hw_scheduler;
    import rv32i_types::*;

    localparam int unsigned W     = 128;
    localparam int unsigned T_OOO = 64;
    localparam int unsigned T_PPL = 16;
    localparam int unsigned RLOW  = 8;
    localparam int unsigned CD    = 2;
    localparam int unsigned W2    = 70002;
    localparam int unsigned T2    = 60000;
    localparam int unsigned N_SAT = 70000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sched_enable;
    logic        ppl_mult, ppl_mem, ppl_flush, ppl_alu, ppl_rob;
    logic        ooo_mult, ooo_mem, ooo_flush, ooo_alu, ooo_rob;
    logic        ppl_drain_ack, ooo_drain_ack;
    logic [31:0] ppl_resume_pc, ooo_resume_pc;
    logic        ppl_drain_req, ooo_drain_req, ppl_en, ooo_en, swap_pc, active_core;
    logic [31:0] sched_pc;

    logic        rst2, d2_mem;
    logic        d2_ppl_drain_req, d2_ooo_drain_req, d2_ppl_en, d2_ooo_en, d2_swap, d2_active;
    logic [31:0] d2_pc;

    hw_scheduler #(.WINDOW(W), .TO_OOO_THRESH(T_OOO), .TO_PPL_THRESH(T_PPL),
                   .ROB_LOW(RLOW), .COOLDOWN(CD)) dut (
        .clk(clk), .rst(rst), .sched_enable(sched_enable),
        .ppl_mult_counter_en(ppl_mult), .ppl_mem_op_counter_en(ppl_mem),
        .ppl_flush_counter_en(ppl_flush), .ppl_alu_op_counter_en(ppl_alu),
        .ppl_rob_full_threshold(ppl_rob),
        .ooo_mult_counter_en(ooo_mult), .ooo_mem_op_counter_en(ooo_mem),
        .ooo_flush_counter_en(ooo_flush), .ooo_alu_op_counter_en(ooo_alu),
        .ooo_rob_full_threshold(ooo_rob),
        .ppl_drain_ack(ppl_drain_ack), .ooo_drain_ack(ooo_drain_ack),
        .ppl_resume_pc(ppl_resume_pc), .ooo_resume_pc(ooo_resume_pc),
        .ppl_drain_req(ppl_drain_req), .ooo_drain_req(ooo_drain_req),
        .ppl_en(ppl_en), .ooo_en(ooo_en),
        .hardware_scheduler_swap_pc(swap_pc), .hardware_scheduler_pc(sched_pc),
        .active_core(active_core));

    hw_scheduler #(.WINDOW(W2), .TO_OOO_THRESH(T2), .TO_PPL_THRESH(T_PPL),
                   .ROB_LOW(RLOW), .COOLDOWN(CD)) dut_sat (
        .clk(clk), .rst(rst2), .sched_enable(1'b1),
        .ppl_mult_counter_en(1'b0), .ppl_mem_op_counter_en(d2_mem),
        .ppl_flush_counter_en(1'b0), .ppl_alu_op_counter_en(1'b0),
        .ppl_rob_full_threshold(1'b0),
        .ooo_mult_counter_en(1'b0), .ooo_mem_op_counter_en(1'b0),
        .ooo_flush_counter_en(1'b0), .ooo_alu_op_counter_en(1'b0),
        .ooo_rob_full_threshold(1'b0),
        .ppl_drain_ack(1'b0), .ooo_drain_ack(1'b0),
        .ppl_resume_pc(32'h0), .ooo_resume_pc(32'h0),
        .ppl_drain_req(d2_ppl_drain_req), .ooo_drain_req(d2_ooo_drain_req),
        .ppl_en(d2_ppl_en), .ooo_en(d2_ooo_en),
        .hardware_scheduler_swap_pc(d2_swap), .hardware_scheduler_pc(d2_pc),
        .active_core(d2_active));

    typedef struct {
        bit          is_swap;
        bit          core;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   m_core, mon_on, sat_done, prev_drain;
    int   m_cd;
    logic [31:0] m_pc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ev = {mult, mem, flush, rob}
    task automatic drive_core(input bit core, input logic [3:0] ev, input logic alu);
        if (core) begin
            {ooo_mult, ooo_mem, ooo_flush, ooo_rob} = ev;
            ooo_alu = alu;
        end else begin
            {ppl_mult, ppl_mem, ppl_flush, ppl_rob} = ev;
            ppl_alu = alu;
        end
    endtask

    // One evaluation window with exact per-event counts on the active core.
    task automatic run_window(input int n_mult, input int n_mem, input int n_flush,
                              input int n_rob, input bit en, output bit drained);
        logic [W-2:0] pat [4];
        int           n [4];
        logic [3:0]   a;
        exp_t         e;
        n = '{n_mult, n_mem, n_flush, n_rob};
        for (int k = 0; k < 4; k++) begin
            pat[k] = '0;
            while ($countones(pat[k]) < n[k]) pat[k][$urandom_range(W - 2, 0)] = 1'b1;
        end
        drained = en && (m_cd == 0) &&
                  (m_core ? ((n_flush >= int'(T_PPL)) && (n_rob < int'(RLOW)))
                          : ((n_mult + n_mem) >= int'(T_OOO)));
        sched_enable = en;
        for (int t = 0; t < int'(W); t++) begin
            if (t < int'(W) - 1) a = {pat[0][t], pat[1][t], pat[2][t], pat[3][t]};
            else                 a = 4'($urandom);
            drive_core(m_core, a, 1'($urandom));
            drive_core(!m_core, 4'($urandom), 1'($urandom));
            if ((t == int'(W) - 1) && drained) begin
                e = '{is_swap: 1'b0, core: m_core, pc: 32'h0, cyc: cyc + 1};
                sb.push_back(e);
            end
            step();
        end
        if (m_cd > 0) m_cd--;
    endtask

    task automatic do_swap(input int delay, input logic [31:0] pc);
        exp_t e;
        drive_core(1'b0, 4'h0, 1'b0);
        drive_core(1'b1, 4'h0, 1'b0);
        for (int i = 0; i < delay; i++) begin
            sched_enable = 1'($urandom);
            if (m_core) begin ooo_drain_ack = 1'b0; ppl_drain_ack = 1'($urandom); end
            else        begin ppl_drain_ack = 1'b0; ooo_drain_ack = 1'($urandom); end
            ppl_resume_pc = $urandom;
            ooo_resume_pc = $urandom;
            step();
        end
        if (m_core) begin
            ooo_drain_ack = 1'b1; ppl_drain_ack = 1'b0; ooo_resume_pc = pc; ppl_resume_pc = ~pc;
        end else begin
            ppl_drain_ack = 1'b1; ooo_drain_ack = 1'b0; ppl_resume_pc = pc; ooo_resume_pc = ~pc;
        end
        e = '{is_swap: 1'b1, core: !m_core, pc: pc, cyc: cyc + 1};
        sb.push_back(e);
        step();
        ppl_drain_ack = 1'b0;
        ooo_drain_ack = 1'b0;
        ppl_resume_pc = $urandom;
        ooo_resume_pc = $urandom;
        m_core = !m_core;
        m_pc   = pc;
        m_cd   = CD;
        step();
    endtask

    task automatic reset_in_drain();
        drive_core(1'b0, 4'h0, 1'b0);
        drive_core(1'b1, 4'h0, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_drain_ppl_en", ppl_en, 1);
        chk("rst_mid_drain_ooo_en", ooo_en, 0);
        chk("rst_mid_drain_reqs", {ppl_drain_req, ooo_drain_req}, 0);
        chk("rst_mid_drain_active_core", active_core, 0);
        chk("rst_mid_drain_swap_pc", swap_pc, 0);
        m_core = 1'b0;
        m_pc   = '0;
        m_cd   = 0;
        rst    = 1'b0;
    endtask

    // Monitor: pops expected events when the DUT presents them and checks per-cycle invariants.
    always @(negedge clk) begin
        if (mon_on) begin
            if ((ppl_drain_req || ooo_drain_req) && !prev_drain) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_drain: got drain_req expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("drain_event_kind", {1'b1, swap_pc}, e.is_swap ? 2'b01 : 2'b10);
                    chk("drain_core", {ppl_drain_req, ooo_drain_req}, e.core ? 2'b01 : 2'b10);
                    chk("drain_cycle", cyc, e.cyc);
                end
            end
            if (swap_pc) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_swap: got swap_pc expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("swap_event_kind", {1'b0, swap_pc}, e.is_swap ? 2'b01 : 2'b10);
                    chk("swap_pc_value", sched_pc, e.pc);
                    chk("swap_new_core", active_core, e.core);
                    chk("swap_cycle", cyc, e.cyc);
                end
            end
            if (ppl_drain_req || ooo_drain_req || swap_pc)
                chk("en_both_low", {ppl_en, ooo_en}, 2'b00);
            else
                chk("en_one_hot", {ppl_en, ooo_en}, m_core ? 2'b01 : 2'b10);
            chk("active_core", active_core, m_core);
            chk("pc_held", sched_pc, m_pc);
            prev_drain = ppl_drain_req || ooo_drain_req;
        end
    end

    // Saturation: 70000 strobes in one window must read as 16'hFFFF (>= 60000), not wrap to 4464.
    initial begin
        rst2   = 1'b1;
        d2_mem = 1'b0;
        repeat (2) step();
        rst2   = 1'b0;
        d2_mem = 1'b1;
        repeat (N_SAT) step();
        d2_mem = 1'b0;
        step();
        chk("sat_no_early_drain", d2_ppl_drain_req, 0);
        step();
        chk("sat_drain_at_window_end", d2_ppl_drain_req, 1);
        sat_done = 1'b1;
    end

    initial begin
        bit d;
        int a, b, f, r;
        bit en;
        rst = 1'b1; sched_enable = 1'b1; mon_on = 1'b0;
        ppl_drain_ack = 1'b0; ooo_drain_ack = 1'b0;
        ppl_resume_pc = '0; ooo_resume_pc = '0;
        drive_core(1'b0, 4'h0, 1'b0);
        drive_core(1'b1, 4'h0, 1'b0);
        m_core = 1'b0; m_pc = '0; m_cd = 0;
        repeat (3) step();
        chk("reset_active_core", active_core, 0);
        chk("reset_ppl_en", ppl_en, 1);
        chk("reset_ooo_en", ooo_en, 0);
        chk("reset_drain_reqs", {ppl_drain_req, ooo_drain_req}, 0);
        chk("reset_swap_pc", swap_pc, 0);
        chk("reset_pc", sched_pc, 0);
        rst = 1'b0;
        mon_on = 1'b1;

        // Pipelined core: below threshold, boundary 63, disabled, then exactly 64.
        run_window(0, 5, 0, 0, 1'b1, d);
        run_window(30, 33, 40, 0, 1'b1, d);
        run_window(60, 40, 0, 0, 1'b0, d);
        run_window(31, 33, 0, 0, 1'b1, d);
        if (d) do_swap(10, 32'h0000_1040);

        // OoO core: cooldown suppression, rob boundary, flush boundary, then qualifying.
        run_window(0, 0, 100, 0, 1'b1, d);
        run_window(0, 0, 100, 0, 1'b1, d);
        run_window(0, 0, 20, 9, 1'b1, d);
        run_window(0, 0, 20, 8, 1'b1, d);
        run_window(0, 0, 15, 0, 1'b1, d);
        run_window(0, 0, 20, 3, 1'b1, d);
        if (d) reset_in_drain();

        // Full round trip with cooldown on the pipelined side.
        run_window(50, 50, 0, 0, 1'b1, d);
        if (d) do_swap(int'($urandom_range(0, 12)), $urandom);
        run_window(0, 0, 20, 3, 1'b1, d);
        run_window(0, 0, 20, 3, 1'b1, d);
        run_window(0, 0, 16, 7, 1'b1, d);
        if (d) do_swap(int'($urandom_range(0, 12)), $urandom);
        run_window(40, 60, 0, 0, 1'b1, d);
        run_window(60, 40, 0, 0, 1'b1, d);
        run_window(40, 60, 0, 0, 1'b1, d);
        if (d) do_swap(int'($urandom_range(0, 12)), $urandom);

        for (int i = 0; i < 20; i++) begin
            a  = int'($urandom_range(0, 60));
            b  = int'($urandom_range(0, 60));
            f  = int'($urandom_range(0, 30));
            r  = int'($urandom_range(0, 14));
            en = ($urandom_range(0, 3) != 0);
            run_window(a, b, f, r, en, d);
            if (d) do_swap(int'($urandom_range(0, 12)), $urandom);
        end

        drive_core(1'b0, 4'h0, 1'b0);
        drive_core(1'b1, 4'h0, 1'b0);
        repeat (4) step();
        chk("scoreboard_drained", sb.size(), 0);

        for (int i = 0; i < 80000 && !sat_done; i++) step();
        chk("sat_test_completed", sat_done, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
